// File: rtl/seq_sub_pkg.sv
// seq_sub_pkg: shared state encoding, default sizes and counter sizing for the sliced subtractor.
package seq_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 4;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sub_slice.sv
// sub_slice: CHUNK-bit adder slice with carry in/out, reused once per cycle by seq_sub_32b.
module sub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/seq_sub_32b.sv
// seq_sub_32b: multi-cycle a - b computed as a + ~b + 1, one CHUNK slice per clock.
// Define SEQ_SUB_CMP_EN to add the lt_u / eq compare outputs.
module seq_sub_32b
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
`ifdef SEQ_SUB_CMP_EN
  ,
  output logic             lt_u,
  output logic             eq
`endif
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW = cnt_w(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("seq_sub_32b: WIDTH must be a multiple of CHUNK");
  end
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, nb_q, nb_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, borrow_q, borrow_d, ovf_q, ovf_d;
  logic [CHUNK-1:0] s;
  logic cout;
  sub_slice #(.CHUNK(CHUNK)) u_slice (
    .x   (a_q[cnt_q*CHUNK +: CHUNK]),
    .y   (nb_q[cnt_q*CHUNK +: CHUNK]),
    .cin (carry_q),
    .s   (s),
    .cout(cout)
  );
`ifdef SEQ_SUB_CMP_EN
  logic eq_q, eq_d;
`endif
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    nb_d     = nb_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
`ifdef SEQ_SUB_CMP_EN
    eq_d     = eq_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        a_d      = a;
        nb_d     = ~b;
        carry_d  = 1'b1;
        cnt_d    = '0;
        diff_d   = '0;
        borrow_d = 1'b0;
        ovf_d    = 1'b0;
`ifdef SEQ_SUB_CMP_EN
        eq_d     = 1'b0;
`endif
      end
      RUN: begin
        diff_d[cnt_q*CHUNK +: CHUNK] = s;
        carry_d = cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          borrow_d = ~cout;
          // operands of equal sign cannot overflow; nb holds ~b so equal bits mean opposite signs
          ovf_d    = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (s[CHUNK-1] != a_q[WIDTH-1]);
`ifdef SEQ_SUB_CMP_EN
          eq_d     = ~|diff_d;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      nb_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SEQ_SUB_CMP_EN
      eq_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
`ifdef SEQ_SUB_CMP_EN
      eq_q     <= eq_d;
`endif
    end
  end
  assign ready  = state_q == IDLE;
  assign done   = state_q == DONE;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
`ifdef SEQ_SUB_CMP_EN
  assign lt_u   = borrow_q;
  assign eq     = eq_q;
`endif
endmodule

// File: tb/tb_seq_sub_32b.sv
// tb_seq_sub_32b: randomized and directed checks of seq_sub_32b against a transaction-level model.
module tb_seq_sub_32b;
  localparam int W = 32;
  localparam int C = 4;
  localparam int NS = W / C;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic ready, done, borrow, ovf;
  logic [W-1:0] diff;
`ifdef SEQ_SUB_CMP_EN
  logic lt_u, eq;
`endif
  seq_sub_32b dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
`ifdef SEQ_SUB_CMP_EN
    , .lt_u(lt_u), .eq(eq)
`endif
  );
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0, cyc = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Model: remaining busy cycles after acceptance plus the full-width expected result.
  int m_left = 0;
  logic [W-1:0] m_diff = '0;
  logic m_borrow = 1'b0, m_ovf = 1'b0;
  bit armed = 0;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_left = 0; m_diff = '0; m_borrow = 1'b0; m_ovf = 1'b0; armed = 1;
    end else if (m_left == 0 && start) begin
      m_left   = NS + 1;
      m_diff   = a - b;
      m_borrow = a < b;
      m_ovf    = (a[W-1] != b[W-1]) && (m_diff[W-1] != a[W-1]);
    end else if (m_left > 0) m_left--;
  end
  always @(negedge clk) if (armed) begin
    chk("ready", ready, m_left == 0);
    chk("done", done, m_left == 1);
    if (m_left >= 2) begin
      int k;
      logic [63:0] mask;
      k = NS + 1 - m_left;
      mask = (k * C >= W) ? {32'd0, {W{1'b1}}} : ((64'd1 << (k * C)) - 64'd1);
      chk("diff_partial", diff, m_diff & mask[W-1:0]);
      chk("borrow_run", borrow, 0);
      chk("ovf_run", ovf, 0);
    end else begin
      chk("diff", diff, m_diff);
      chk("borrow", borrow, m_borrow);
      chk("ovf", ovf, m_ovf);
`ifdef SEQ_SUB_CMP_EN
      chk("lt_u", lt_u, m_borrow);
      chk("eq", eq, (m_left == 1 || m_diff != 0 || m_borrow || m_ovf) ? (m_diff == 0 && m_left <= 1 && !(m_left == 0 && m_diff == 0 && !armed)) : eq);
`endif
    end
  end
  task automatic go(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, done, 1);
  endtask
  task automatic op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    go(x, y);
    wait_done(nm, n);
    chk({nm, "_latency"}, n, NS);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_borrow"}, borrow, eb);
    chk({nm, "_ovf"}, ovf, eo);
`ifdef SEQ_SUB_CMP_EN
    chk({nm, "_eq"}, eq, ed == 0);
    chk({nm, "_lt_u"}, lt_u, eb);
`endif
  endtask
  initial begin
    int n, t0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_diff", diff, 0);
    rst_n = 1'b1;
    op("t1", 32'd84, 32'd35, 32'd49, 1'b0, 1'b0);
    op("t2", 32'd35, 32'd84, 32'hFFFFFFCF, 1'b1, 1'b0);
    op("t3a", 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1);
    op("t3b", 32'd55, 32'd55, 32'd0, 1'b0, 1'b0);
    go(32'd84, 32'd35);
    a = 32'd55; b = 32'd68; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4", n);
    chk("t4_diff", diff, 32'd49);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t4_single_done", done, 0);
    end
    go(32'd84, 32'd35);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_ready", ready, 1);
    chk("t5_diff", diff, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t5_no_done", done, 0);
    end
    @(negedge clk);
    a = 32'd100; b = 32'd1; start = 1'b1;
    t0 = -1;
    for (int i = 0; i < 3; i++) begin
      wait_done("t6", n);
      chk("t6_diff", diff, 32'd99);
      if (t0 >= 0) chk("t6_period", cyc - t0, 10);
      t0 = cyc;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom % 3) == 0;
      case ($urandom % 6)
        0: a = 32'h80000000;
        1: a = 32'h7FFFFFFF;
        2: a = '0;
        default: a = $urandom;
      endcase
      b = ($urandom % 5 == 0) ? a : (($urandom % 4 == 0) ? 32'hFFFFFFFF : $urandom);
      rst_n = ($urandom % 80) != 0;
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
